// File: rtl/dispenser_arbiter.sv
// Round-robin arbiter sharing one fill nozzle among four drink FSMs; optional cup timeout via DISPENSE_TIMEOUT_EN.
// Latency: GNT two cycles after REQ, DONE 7 (small) / 11 (large) cycles after REQ with the cup present.
// Backpressure: requests wait while BUSY; the served requester is never preempted, M low stalls the fill.
module dispenser_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] REQ,
    input  logic [7:0] SIZE,
    input  logic       M,
    output logic [3:0] GNT,
    output logic       VALVE,
    output logic [3:0] DONE,
    output logic [3:0] ABORT,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_WAIT_CUP,
        S_FILL,
        S_RELEASE
    } state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_win;
    logic       r_large;
    logic [3:0] r_cnt;
    logic [3:0] r_gnt;
    logic [3:0] r_done;

    logic [1:0] w_win_idx;
    logic       w_win_vld;
    logic [1:0] w_cand;
    logic       w_req_held;
    logic       w_valve;
    logic [3:0] w_last_cnt;

`ifdef DISPENSE_TIMEOUT_EN
    logic [3:0] r_tmr;
    logic [3:0] r_abort;
`endif

    // Scan from the highest offset down so the lowest offset from PTR wins.
    always_comb begin
        w_win_idx = r_ptr;
        w_win_vld = 1'b0;
        w_cand    = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_cand = r_ptr + 2'(k);
            if (REQ[w_cand]) begin
                w_win_idx = w_cand;
                w_win_vld = 1'b1;
            end
        end
    end

    assign w_req_held = REQ[r_win];
    // Combinational so a lost cup, a dropped request or reset shuts the valve within the cycle.
    assign w_valve    = (r_state == S_FILL) && M && w_req_held;
    assign w_last_cnt = r_large ? 4'd7 : 4'd3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_win   <= 2'd0;
            r_large <= 1'b0;
            r_cnt   <= 4'd0;
            r_gnt   <= 4'd0;
            r_done  <= 4'd0;
`ifdef DISPENSE_TIMEOUT_EN
            r_tmr   <= 4'd0;
            r_abort <= 4'd0;
`endif
        end else begin
            r_done <= 4'd0;
`ifdef DISPENSE_TIMEOUT_EN
            r_abort <= 4'd0;
            r_tmr   <= 4'd0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (|REQ) r_state <= S_ARB;
                end
                S_ARB: begin
                    if (w_win_vld) begin
                        r_win   <= w_win_idx;
                        r_large <= (SIZE[{w_win_idx, 1'b0} +: 2] == 2'b10);
                        r_gnt   <= 4'b0001 << w_win_idx;
                        r_state <= S_WAIT_CUP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_CUP: begin
                    if (!w_req_held) begin
                        r_state <= S_RELEASE;
                    end else if (M) begin
                        r_state <= S_FILL;
`ifdef DISPENSE_TIMEOUT_EN
                    end else if (r_tmr == 4'd15) begin
                        r_abort <= r_gnt;
                        r_state <= S_RELEASE;
                    end else begin
                        r_tmr <= r_tmr + 4'd1;
`endif
                    end
                end
                S_FILL: begin
                    if (!w_req_held) begin
                        r_state <= S_RELEASE;
                    end else if (w_valve) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == w_last_cnt) begin
                            r_done  <= r_gnt;
                            r_state <= S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    r_ptr   <= r_win + 2'd1;
                    r_cnt   <= 4'd0;
                    r_gnt   <= 4'd0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign GNT   = r_gnt;
    assign VALVE = w_valve;
    assign DONE  = r_done;
    assign BUSY  = (r_state != S_IDLE);
`ifdef DISPENSE_TIMEOUT_EN
    assign ABORT = r_abort;
`else
    assign ABORT = 4'd0;
`endif

endmodule

// File: tb/tb_dispenser_arbiter.sv
// Directed scenarios with literal expectations, then randomized traffic checked against a sequential behavioural model.
module tb_dispenser_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] REQ;
    logic [7:0] SIZE;
    logic       M;
    logic [3:0] GNT;
    logic       VALVE;
    logic [3:0] DONE;
    logic [3:0] ABORT;
    logic       BUSY;

    always #5 clk = ~clk;

    dispenser_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .REQ   (REQ),
        .SIZE  (SIZE),
        .M     (M),
        .GNT   (GNT),
        .VALVE (VALVE),
        .DONE  (DONE),
        .ABORT (ABORT),
        .BUSY  (BUSY)
    );

    int checks = 0;
    int errors = 0;
    logic model_go = 1'b0;

    logic [3:0] req_a  [0:79];
    logic       m_a    [0:79];
    logic [3:0] gnt_h  [0:79];
    logic [3:0] done_h [0:79];
    logic [3:0] abort_h[0:79];
    logic       valve_h[0:79];
    logic       busy_h [0:79];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Cycle 0 starts just after a rising edge; outputs are recorded at the falling edge.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            REQ = req_a[c];
            M   = m_a[c];
            @(negedge clk);
            gnt_h[c]   = GNT;
            done_h[c]  = DONE;
            abort_h[c] = ABORT;
            valve_h[c] = VALVE;
            busy_h[c]  = BUSY;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input logic [3:0] r, input int n);
        for (int c = 0; c < 80; c++) begin
            req_a[c] = (c < n) ? r : 4'd0;
            m_a[c]   = 1'b1;
        end
    endtask

    function automatic int first_nz(input int sel, input int n);
        for (int c = 0; c < n; c++) begin
            if (sel == 0 && done_h[c] != 0) return c;
            if (sel == 1 && abort_h[c] != 0) return c;
            if (sel == 2 && valve_h[c]) return c;
        end
        return -1;
    endfunction

    function automatic int valve_count(input int n);
        int cnt = 0;
        for (int c = 0; c < n; c++) if (valve_h[c]) cnt++;
        return cnt;
    endfunction

    task automatic do_reset();
        REQ   = 4'd0;
        M     = 1'b0;
        SIZE  = 8'd0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("reset_outputs", int'({GNT, VALVE, DONE, ABORT, BUSY}), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input logic [3:0] g, input logic v, input logic [3:0] d,
                           input logic [3:0] a, input logic b, input string ph);
        chk({"model_", ph}, int'({GNT, VALVE, DONE, ABORT, BUSY}), int'({g, v, d, a, b}));
    endtask

    // Reference: one service episode written as a sequential story, one step per falling edge.
    initial begin : model
        logic [3:0] r;
        logic [3:0] g;
        logic [7:0] sz;
        logic       v;
        int w, tgt, filled, waited, outcome, ptr_m;
        logic go_fill;
        wait (model_go);
        ptr_m = 0;
        @(negedge clk);
        forever begin
            exp_out(4'd0, 1'b0, 4'd0, 4'd0, 1'b0, "idle");
            r = REQ;
            @(negedge clk);
            if (r == 4'd0) continue;
            exp_out(4'd0, 1'b0, 4'd0, 4'd0, 1'b1, "arb");
            r  = REQ;
            sz = SIZE;
            @(negedge clk);
            if (r == 4'd0) continue;
            w = -1;
            for (int k = 3; k >= 0; k--) if (r[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
            tgt     = (sz[2*w +: 2] == 2'b10) ? 8 : 4;
            g       = 4'(1 << w);
            outcome = 0;
            waited  = 0;
            go_fill = 1'b0;
            forever begin
                exp_out(g, 1'b0, 4'd0, 4'd0, 1'b1, "wait_cup");
                if (!REQ[w]) begin @(negedge clk); break; end
                if (M) begin go_fill = 1'b1; @(negedge clk); break; end
                waited++;
`ifdef DISPENSE_TIMEOUT_EN
                if (waited == 16) begin outcome = 2; @(negedge clk); break; end
`endif
                @(negedge clk);
            end
            if (go_fill) begin
                filled = 0;
                forever begin
                    v = M && REQ[w];
                    exp_out(g, v, 4'd0, 4'd0, 1'b1, "fill");
                    if (!REQ[w]) begin @(negedge clk); break; end
                    if (v) filled++;
                    @(negedge clk);
                    if (filled == tgt) begin outcome = 1; break; end
                end
            end
            exp_out(g, 1'b0, (outcome == 1) ? g : 4'd0, (outcome == 2) ? g : 4'd0, 1'b1, "release");
            ptr_m = (w + 1) % 4;
            @(negedge clk);
        end
    end

    initial begin
        int e;
        int mlow;
        logic [3:0] nr;

        // Single small fill for requester 1.
        do_reset();
        SIZE = 8'b0000_0100;
        fill(4'b0010, 8);
        run(10);
        chk("A_gnt_c1", gnt_h[1], 0);
        chk("A_busy_c1", busy_h[1], 1);
        chk("A_gnt_c2", gnt_h[2], 4'b0010);
        chk("A_gnt_c7", gnt_h[7], 4'b0010);
        chk("A_valve_first", first_nz(2, 10), 3);
        chk("A_valve_count", valve_count(10), 4);
        chk("A_done_cycle", first_nz(0, 10), 7);
        chk("A_done_value", done_h[7], 4'b0010);
        chk("A_busy_c8", busy_h[8], 0);
        chk("A_gnt_c8", gnt_h[8], 0);

        // All four requesting large cups: rotation 0,1,2,3,0 every 12 cycles.
        do_reset();
        SIZE = 8'hAA;
        fill(4'hF, 80);
        run(62);
        e = 0;
        for (int c = 0; c < 62; c++) begin
            if (done_h[c] != 0) begin
                if (e < 5) begin
                    chk("B_done_cycle", c, 11 + 12 * e);
                    chk("B_done_value", done_h[c], 1 << (e % 4));
                end
                e++;
            end
        end
        chk("B_done_events", e, 5);

        // Large fill with the cup removed for three cycles after the second valve cycle.
        do_reset();
        SIZE = 8'h02;
        fill(4'b0001, 15);
        m_a[5] = 1'b0;
        m_a[6] = 1'b0;
        m_a[7] = 1'b0;
        run(17);
        chk("C_valve_c4", valve_h[4], 1);
        chk("C_valve_gap", int'(valve_h[5] | valve_h[6] | valve_h[7]), 0);
        chk("C_valve_c8", valve_h[8], 1);
        chk("C_valve_count", valve_count(17), 8);
        chk("C_done_cycle", first_nz(0, 17), 14);

        // Requester 0 gives up on the third fill cycle; PTR moves on to requester 1.
        do_reset();
        SIZE = 8'd0;
        fill(4'b0011, 80);
        req_a[5] = 4'b0010;
        req_a[6] = 4'b0010;
        run(11);
        chk("D_valve_c4", valve_h[4], 1);
        chk("D_valve_c5", valve_h[5], 0);
        chk("D_no_done", first_nz(0, 11), -1);
        chk("D_no_abort", first_nz(1, 11), -1);
        chk("D_gnt_release", gnt_h[6], 4'b0001);
        chk("D_busy_c7", busy_h[7], 0);
        chk("D_gnt_next", gnt_h[9], 4'b0010);

        // Cup never arrives.
        do_reset();
        fill(4'b0100, 80);
        for (int c = 0; c < 80; c++) m_a[c] = 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
        run(20);
        chk("E_gnt_c17", gnt_h[17], 4'b0100);
        chk("E_abort_cycle", first_nz(1, 20), 18);
        chk("E_abort_value", abort_h[18], 4'b0100);
        chk("E_no_done", first_nz(0, 20), -1);
        chk("E_busy_c19", busy_h[19], 0);
`else
        run(40);
        chk("E_gnt_hold", gnt_h[39], 4'b0100);
        chk("E_no_abort", first_nz(1, 40), -1);
        chk("E_no_done", first_nz(0, 40), -1);
`endif

        // Reset in the middle of a fill, with PTR previously moved to 2.
        do_reset();
        fill(4'b0010, 8);
        run(9);
        chk("F_first_done", done_h[7], 4'b0010);
        SIZE = 8'b0010_0000;
        fill(4'b0100, 80);
        run(6);
        chk("F_valve_before", VALVE, 1);
        #2 reset = 1'b1;
        #1;
        chk("F_async_clear", int'({VALVE, GNT, BUSY, DONE, ABORT}), 0);
        @(negedge clk);
        reset = 1'b0;
        REQ   = 4'd0;
        @(posedge clk);
        #1;
        fill(4'b0101, 80);
        run(4);
        chk("F_gnt_from_ptr0", gnt_h[2], 4'b0001);

        // Randomized traffic against the model.
        do_reset();
        model_go = 1'b1;
        mlow = 0;
        for (int n = 0; n < 3000; n++) begin
            nr = REQ;
            for (int i = 0; i < 4; i++) begin
                if (nr[i] && (DONE[i] || ABORT[i])) nr[i] = 1'b0;
                else if (nr[i] && ($urandom % 80 == 0)) nr[i] = 1'b0;
                else if (!nr[i] && ($urandom % 4 == 0)) nr[i] = 1'b1;
            end
            REQ  = nr;
            SIZE = 8'($urandom);
            if (mlow > 0) begin
                M = 1'b0;
                mlow--;
            end else begin
                M = ($urandom % 4) != 0;
                if ($urandom % 150 == 0) mlow = 20;
            end
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispenser_arbiter.md
DISPENSER_ARBITER -- requirements
Module: dispenser_arbiter

Interface
REQ-001 The block SHALL have the port: clk, input, 1, single system clock; every flop is rising-edge.
REQ-002 The block SHALL have the port: reset, input, 1, asynchronous, active-high reset.
REQ-003 The block SHALL have the port: REQ, input, 4, per-drink dispense request from the drink FSMs; held high until that requester's DONE or ABORT.
REQ-004 The block SHALL have the port: SIZE, input, 8, cup size for requester i on SIZE[2i+1:2i]: 01 = small, 10 = large, 00/11 = small.
REQ-005 The block SHALL have the port: M, input, 1, cup-present sensor under the shared nozzle.
REQ-006 The block SHALL have the port: GNT, output, 4, one-hot grant; all zero when no requester is served.
REQ-007 The block SHALL have the port: VALVE, output, 1, shared fill valve open.
REQ-008 The block SHALL have the port: DONE, output, 4, one-cycle completion pulse to the served requester.
REQ-009 The block SHALL have the port: ABORT, output, 4, one-cycle abort pulse to the served requester.
REQ-010 The block SHALL have the port: BUSY, output, 1, high in every state except IDLE.

Function
REQ-011 The block SHALL implement exactly five states: IDLE, ARB, WAIT_CUP, FILL and RELEASE.
REQ-012 In IDLE with REQ != 0, the block SHALL enter ARB on the next edge; with REQ == 0 it SHALL remain in IDLE.
REQ-013 In ARB, the block SHALL select one requester round-robin, starting at index PTR and searching upward modulo 4.
REQ-014 In ARB, the block SHALL latch the winner index and its 2-bit SIZE, and assert GNT for that requester from the next cycle.
REQ-015 If REQ == 0 in ARB, the block SHALL return to IDLE with no grant.
REQ-016 From ARB with a winner, the block SHALL enter WAIT_CUP, with GNT held one-hot on the winner through WAIT_CUP, FILL and RELEASE.
REQ-017 In WAIT_CUP with M == 1, the block SHALL enter FILL.
REQ-018 In WAIT_CUP, if the granted REQ bit drops, the block SHALL enter RELEASE with no DONE.
REQ-019 In FILL, VALVE SHALL be high exactly while state == FILL and M == 1.
REQ-020 In FILL, a 4-bit fill counter SHALL count VALVE-high cycles.
REQ-021 The target fill count SHALL be 4 cycles for small and 8 cycles for large.
REQ-022 In FILL, if M drops, VALVE SHALL go low in the same cycle and the counter SHALL hold until M returns, with no timeout.
REQ-023 In FILL, when the counter reaches the target, the block SHALL pulse DONE[winner] for one cycle and enter RELEASE in the same cycle that VALVE falls.
REQ-024 In FILL, if the granted REQ bit drops, VALVE SHALL close immediately and the block SHALL enter RELEASE with no DONE.
REQ-025 In RELEASE, the block SHALL set PTR = winner+1 modulo 4, clear the fill counter and return to IDLE on the next edge; GNT SHALL be zero from IDLE onward.
REQ-026 The minimum request-to-DONE latency SHALL be 7 cycles for small and 11 cycles for large, with M already high.
REQ-027 New requests arriving while BUSY SHALL wait; they SHALL never preempt the served requester.
REQ-028 With all four REQ bits continuously high, the block SHALL serve requesters 0, 1, 2, 3, 0 in that order.
REQ-029 DONE and ABORT SHALL never be high in the same cycle, and each SHALL be at most one-hot.

Reset
REQ-030 While reset is high, the block SHALL hold state = IDLE, PTR = 0, fill counter = 0, and GNT = VALVE = DONE = ABORT = BUSY = 0, independent of clk.
REQ-031 On a reset assertion mid-FILL, the block SHALL close VALVE asynchronously within the same cycle and SHALL issue no DONE or ABORT.

Configuration
REQ-032 With macro DISPENSE_TIMEOUT_EN defined, a 4-bit timer SHALL count cycles in WAIT_CUP.
REQ-033 With DISPENSE_TIMEOUT_EN defined, after 16 cycles without M the block SHALL pulse ABORT[winner] for one cycle and enter RELEASE.
REQ-034 With DISPENSE_TIMEOUT_EN defined, the timer SHALL clear on leaving WAIT_CUP.
REQ-035 Without DISPENSE_TIMEOUT_EN, WAIT_CUP SHALL wait indefinitely and ABORT SHALL be tied to 0.

Verification
REQ-036 The bench SHALL cover: reset, REQ=0010, SIZE[3:2]=01, M=1 -> GNT=0010 from cycle 2, VALVE high for 4 cycles, DONE=0010 at cycle 7, BUSY low after RELEASE.
REQ-037 The bench SHALL cover: REQ=1111 held, all sizes large, M=1 -> DONE pulses in order 0001, 0010, 0100, 1000, 0001, each 12 cycles apart.
REQ-038 The bench SHALL cover: large fill, M dropped for 3 cycles after the 2nd valve cycle -> VALVE low for those 3 cycles, exactly 8 VALVE-high cycles total, DONE delayed by 3.
REQ-039 The bench SHALL cover: served REQ dropped at the 3rd FILL cycle -> VALVE low that cycle, no DONE, PTR advanced, next requester granted.
REQ-040 The bench SHALL cover: DISPENSE_TIMEOUT_EN defined, REQ=0100, M=0 -> ABORT=0100 after 16 WAIT_CUP cycles; without the macro, GNT holds indefinitely.
REQ-041 The bench SHALL cover: reset asserted mid-FILL -> VALVE, GNT and BUSY 0 immediately; after release, REQ=0001 is served from PTR=0.
